// File: rtl/interrupt_request_array_if.sv
// interrupt_request_array_if: request/config inputs and pending-request outputs of the IRR.
//  master (control side): drives pins, polarity/mode config, freeze, clear, software requests.
//  slave (IRR side): returns interrupt_request_register and interrupt_pending.
interface interrupt_request_array_if #(parameter int NUM_IRQ = 8);
  logic [NUM_IRQ-1:0] interrupt_request_pin;
  logic [NUM_IRQ-1:0] active_low_config;
  logic [NUM_IRQ-1:0] level_triggered_config;
  logic               freeze;
  logic [NUM_IRQ-1:0] clear_interrupt_request;
  logic [NUM_IRQ-1:0] software_request;
  logic [NUM_IRQ-1:0] interrupt_request_register;
  logic               interrupt_pending;
  modport master (
    output interrupt_request_pin, active_low_config, level_triggered_config,
           freeze, clear_interrupt_request, software_request,
    input  interrupt_request_register, interrupt_pending
  );
  modport slave (
    input  interrupt_request_pin, active_low_config, level_triggered_config,
           freeze, clear_interrupt_request, software_request,
    output interrupt_request_register, interrupt_pending
  );
endinterface

// File: rtl/interrupt_request_array.sv
// interrupt_request_array: synchronised, glitch-filtered, polarity/mode-configurable interrupt request register.
//  clock, reset (sync, active-high); bus (slave): pins/config/freeze/clear/software in, IRR/pending out.
module interrupt_request_array #(
  parameter int NUM_IRQ       = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3
) (
  input logic                      clock,
  input logic                      reset,
  interrupt_request_array_if.slave bus
);
  logic [NUM_IRQ-1:0] sync_last, synced, filtered;
  logic [NUM_IRQ-1:0] arm_q, arm_d, soft_q, soft_d, irr_q, irr_d;
  logic [NUM_IRQ-1:0] clr, lvl;
  assign clr = bus.clear_interrupt_request;
  assign lvl = bus.level_triggered_config;
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sync_last = bus.interrupt_request_pin;
    end else begin : g_sync
      logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
      logic [NUM_IRQ-1:0] sync_d [SYNC_STAGES];
      always_comb begin
        sync_d[0] = bus.interrupt_request_pin;
        for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
      end
      always_ff @(posedge clock)
        for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= reset ? '0 : sync_d[k];
      assign sync_last = sync_q[SYNC_STAGES-1];
    end
  endgenerate
  // polarity is applied after the chain so the flops always see the raw pin
  assign synced = sync_last ^ bus.active_low_config;
  generate
    if (FILTER_CYCLES == 0) begin : g_nofilt
      assign filtered = synced;
    end else begin : g_filt
      localparam int CW = $clog2(FILTER_CYCLES + 1);
      localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);
      logic [CW-1:0]      cnt_q [NUM_IRQ];
      logic [CW-1:0]      cnt_d [NUM_IRQ];
      logic [NUM_IRQ-1:0] filt_q, filt_d;
      // a disagreement must persist FILTER_CYCLES consecutive cycles before the level is accepted
      always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < NUM_IRQ; i++) begin
          cnt_d[i]  = (synced[i] == filt_q[i] || cnt_q[i] == LAST) ? '0 : cnt_q[i] + CW'(1);
          filt_d[i] = (synced[i] != filt_q[i] && cnt_q[i] == LAST) ? synced[i] : filt_q[i];
        end
      end
      always_ff @(posedge clock) begin
        filt_q <= reset ? '0 : filt_d;
        for (int i = 0; i < NUM_IRQ; i++) cnt_q[i] <= reset ? '0 : cnt_d[i];
      end
      assign filtered = filt_q;
    end
  endgenerate
  // arm re-sets only while the line is low, so a clear during a held-high line blocks recapture
  always_comb begin
    arm_d  = ~clr & (arm_q | ~filtered);
    soft_d = ~clr & (soft_q | bus.software_request);
    irr_d  = ~clr & (bus.freeze ? irr_q
                                : (lvl & (filtered | soft_q)) | (~lvl & (irr_q | (arm_q & filtered) | soft_q)));
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      arm_q  <= '0;
      soft_q <= '0;
      irr_q  <= '0;
    end else begin
      arm_q  <= arm_d;
      soft_q <= soft_d;
      irr_q  <= irr_d;
    end
  end
  assign bus.interrupt_request_register = irr_q;
  assign bus.interrupt_pending          = |irr_q;
endmodule

// File: tb/tb_interrupt_request_array.sv
// tb_interrupt_request_array: scoreboard bench with a per-line reference model, directed and random stimulus.
module tb_interrupt_request_array;
  localparam int N = 8, S = 2, F = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  interrupt_request_array_if #(.NUM_IRQ(N)) bus ();
  interrupt_request_array #(.NUM_IRQ(N), .SYNC_STAGES(S), .FILTER_CYCLES(F)) dut (
    .clock(clk), .reset(rst), .bus(bus)
  );
  int passed = 0, total = 0;
  logic [N-1:0] exp_q [$];
  bit started = 0;
  logic [N-1:0] m_hist [S];
  logic [N-1:0] m_filt, m_arm, m_soft, m_irr;
  int m_run [N];
  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
  endtask
  // reference: per-line behaviour stepped once per clock from the documented rules
  task automatic model_step();
    logic [N-1:0] synced, nf, na, ns, ni;
    if (rst) begin
      for (int k = 0; k < S; k++) m_hist[k] = '0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
      m_filt = '0; m_arm = '0; m_soft = '0; m_irr = '0;
    end else begin
      synced = m_hist[S-1] ^ bus.active_low_config;
      for (int i = 0; i < N; i++) begin
        nf[i] = m_filt[i];
        if (synced[i] == m_filt[i]) m_run[i] = 0;
        else if (m_run[i] + 1 >= F) begin nf[i] = synced[i]; m_run[i] = 0; end
        else m_run[i]++;
        if (bus.clear_interrupt_request[i]) begin
          na[i] = 0; ns[i] = 0; ni[i] = 0;
        end else begin
          na[i] = m_filt[i] ? m_arm[i] : 1'b1;
          ns[i] = m_soft[i] | bus.software_request[i];
          if (bus.freeze) ni[i] = m_irr[i];
          else if (bus.level_triggered_config[i]) ni[i] = m_filt[i] | m_soft[i];
          else ni[i] = m_irr[i] | (m_arm[i] & m_filt[i]) | m_soft[i];
        end
      end
      for (int k = S - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = bus.interrupt_request_pin;
      m_filt = nf; m_arm = na; m_soft = ns; m_irr = ni;
    end
    exp_q.push_back(m_irr);
  endtask
  task automatic cyc();
    @(posedge clk);
    model_step();
    started = 1;
    #1;
  endtask
  task automatic cycles(int n);
    repeat (n) cyc();
  endtask
  initial begin
    logic [N-1:0] e;
    forever begin
      @(negedge clk);
      if (started) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL scoreboard: no expected entry at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("sb_irr", bus.interrupt_request_register, e);
          check("sb_pending", bus.interrupt_pending, |e);
        end
      end
    end
  end
  initial begin
    bus.interrupt_request_pin   = '1;
    bus.active_low_config       = '0;
    bus.level_triggered_config  = '0;
    bus.freeze                  = 1'b0;
    bus.clear_interrupt_request = '0;
    bus.software_request        = '0;
    rst = 1'b1;
    cycles(3);
    check("reset_irr", bus.interrupt_request_register, 0);
    check("reset_pending", bus.interrupt_pending, 0);
    rst = 1'b0;
    cycles(5);
    check("release_irr0_early", bus.interrupt_request_register[0], 0);
    cyc();
    check("release_irr0_cap", bus.interrupt_request_register[0], 1);
    bus.clear_interrupt_request = '1; bus.interrupt_request_pin = '0;
    cyc();
    bus.clear_interrupt_request = '0;
    check("clear_all", bus.interrupt_request_register, 0);
    cycles(8);
    bus.interrupt_request_pin[3] = 1'b1;
    cycles(5);
    check("edge3_early", bus.interrupt_request_register[3], 0);
    cyc();
    check("edge3_cap", bus.interrupt_request_register[3], 1);
    bus.interrupt_request_pin[3] = 1'b0;
    cycles(8);
    check("edge3_sticky", bus.interrupt_request_register[3], 1);
    bus.clear_interrupt_request[3] = 1'b1;
    cyc();
    bus.clear_interrupt_request[3] = 1'b0;
    check("edge3_clear", bus.interrupt_request_register[3], 0);
    bus.level_triggered_config[5] = 1'b1;
    bus.interrupt_request_pin[5] = 1'b1;
    cycles(2);
    bus.interrupt_request_pin[5] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      check("glitch5", bus.interrupt_request_register[5], 0);
    end
    bus.interrupt_request_pin[5] = 1'b1;
    cycles(3);
    bus.interrupt_request_pin[5] = 1'b0;
    cycles(2);
    check("level5_early", bus.interrupt_request_register[5], 0);
    cyc();
    check("level5_set", bus.interrupt_request_register[5], 1);
    cycles(2);
    check("level5_hold", bus.interrupt_request_register[5], 1);
    cyc();
    check("level5_drop", bus.interrupt_request_register[5], 0);
    bus.level_triggered_config[5] = 1'b0;
    bus.freeze = 1'b1;
    bus.interrupt_request_pin[2] = 1'b1;
    cycles(8);
    check("freeze2_hold", bus.interrupt_request_register[2], 0);
    bus.freeze = 1'b0;
    cyc();
    check("freeze2_release", bus.interrupt_request_register[2], 1);
    bus.interrupt_request_pin[2] = 1'b0;
    bus.clear_interrupt_request[2] = 1'b1;
    cyc();
    bus.clear_interrupt_request[2] = 1'b0;
    cycles(8);
    bus.interrupt_request_pin[1] = 1'b1;
    cycles(5);
    bus.clear_interrupt_request[1] = 1'b1;
    cyc();
    bus.clear_interrupt_request[1] = 1'b0;
    check("clr_vs_edge1", bus.interrupt_request_register[1], 0);
    cycles(4);
    check("clr_no_rearm1", bus.interrupt_request_register[1], 0);
    bus.interrupt_request_pin[1] = 1'b0;
    cycles(8);
    bus.interrupt_request_pin[1] = 1'b1;
    cycles(5);
    check("edge1_again_early", bus.interrupt_request_register[1], 0);
    cyc();
    check("edge1_again", bus.interrupt_request_register[1], 1);
    bus.active_low_config[7] = 1'b1;
    bus.interrupt_request_pin[7] = 1'b1;
    cycles(8);
    check("al7_idle", bus.interrupt_request_register[7], 0);
    bus.interrupt_request_pin[7] = 1'b0;
    cycles(5);
    check("al7_early", bus.interrupt_request_register[7], 0);
    cyc();
    check("al7_cap", bus.interrupt_request_register[7], 1);
    bus.software_request[4] = 1'b1;
    cyc();
    bus.software_request[4] = 1'b0;
    check("sw4_early", bus.interrupt_request_register[4], 0);
    cyc();
    check("sw4_set", bus.interrupt_request_register[4], 1);
    bus.clear_interrupt_request[4] = 1'b1;
    cyc();
    bus.clear_interrupt_request[4] = 1'b0;
    check("sw4_clear", bus.interrupt_request_register[4], 0);
    for (int c = 0; c < 1500; c++) begin
      bus.interrupt_request_pin ^= N'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 63) == 0) bus.active_low_config = N'($urandom);
      if ($urandom_range(0, 31) == 0) bus.level_triggered_config = N'($urandom);
      bus.freeze = ($urandom_range(0, 7) == 0);
      bus.clear_interrupt_request = ($urandom_range(0, 5) == 0) ? N'(1 << $urandom_range(0, N - 1)) : '0;
      bus.software_request = ($urandom_range(0, 15) == 0) ? N'(1 << $urandom_range(0, N - 1)) : '0;
      rst = ($urandom_range(0, 299) == 0);
      cyc();
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    started = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
